// File: rtl/instr_mem_loader.sv
// instr_mem_loader: turns a counted, checksummed byte stream into 32-bit
// instruction RAM writes (MSB-first, byte address 4*index) while holding
// the core in reset, then pulses done with an error flag.
module instr_mem_loader #(
   parameter int DEPTH = 64,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] num_words,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          mem_we,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   num_q, num_d;
   logic [IW-1:0]   word_index_q, word_index_d;
   logic [1:0]      byte_count_q, byte_count_d;
   logic [7:0]      sum_q, sum_d;
   logic [23:0]     shreg_q, shreg_d;
   logic            mem_we_q, mem_we_d;
   logic [31:0]     mem_addr_q, mem_addr_d;
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic            cpu_hold_q, cpu_hold_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic            accept;
   logic [CW-1:0]   idx_next;

   // byte_ready depends on state only, never on byte_valid
   assign byte_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
   assign accept     = byte_valid & byte_ready;
   assign idx_next   = CW'(word_index_q) + CW'(1);

   // next-state and next-output computation; outputs are registered so
   // they line up with the state they describe
   always_comb begin
      state_d      = state_q;
      num_d        = num_q;
      word_index_d = word_index_q;
      byte_count_d = byte_count_q;
      sum_d        = sum_q;
      shreg_d      = shreg_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_we_d     = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_words == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if (num_words > DEPTH_C) begin
                  // oversize image: reject without touching the stream
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d      = S_LOAD;
                  num_d        = num_words;
                  word_index_d = '0;
                  byte_count_d = '0;
                  sum_d        = '0;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               shreg_d      = {shreg_q[15:0], byte_data};
               sum_d        = sum_q + byte_data;
               byte_count_d = byte_count_q + 2'd1;
               if (byte_count_q == 2'd3) begin
                  state_d     = S_WRITE;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = {{(30-IW){1'b0}}, word_index_q, 2'b00};
                  mem_wdata_d = {shreg_q, byte_data};
               end
            end
         end
         S_WRITE: begin
            // last word: keep word_index in range instead of wrapping past DEPTH-1
            if (idx_next == num_q) begin
               state_d = S_CHECK;
            end else begin
               state_d      = S_LOAD;
               word_index_d = word_index_q + IW'(1);
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = (byte_data != sum_q);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      cpu_hold_d = (state_d != S_IDLE);
   end

   // state and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         num_q        <= '0;
         word_index_q <= '0;
         byte_count_q <= '0;
         sum_q        <= '0;
         shreg_q      <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_hold_q   <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         num_q        <= num_d;
         word_index_q <= word_index_d;
         byte_count_q <= byte_count_d;
         sum_q        <= sum_d;
         shreg_q      <= shreg_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: loads, checksum failure, edge
// counts, full-depth timing and reset mid-load.
module tb_instr_mem_loader;

   localparam int DEPTH = 64;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [CW-1:0] num_words;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          err;

   instr_mem_loader #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_words  (num_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // observation log, sampled on the falling edge
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          wc[$];
   int          done_cnt = 0;
   int          done_cyc = 0;
   logic        last_err = 1'b0;
   int          hold_cnt = 0;
   int          br_cnt   = 0;

   always @(negedge clk) begin
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
         wc.push_back(cyc);
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
         last_err <= err;
      end
      if (cpu_hold) hold_cnt <= hold_cnt + 1;
      if (byte_ready) br_cnt <= br_cnt + 1;
   end

   int n_chk = 0;
   int n_err = 0;
   int st_cyc;
   int acc_cyc;
   int exp_wc[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input int n);
      start     = 1'b1;
      num_words = CW'(n);
      st_cyc    = cyc;
      tick();
      start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int   t;
      logic rdy;
      byte_valid = 1'b0;
      repeat (gap) tick();
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      do begin
         rdy = byte_ready;
         tick();
         t++;
      end while (!rdy && t < 50);
      if (!rdy) chk("byte_accept_timeout", 32'd0, 32'd1);
      acc_cyc    = cyc;
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_max);
      for (int i = 3; i >= 0; i--)
         send_byte(w[i*8 +: 8], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      exp_wc.push_back(acc_cyc);
   endtask

   task automatic wait_done(input int base);
      int t;
      t = 0;
      while (done_cnt == base && t < 1000) begin
         tick();
         t++;
      end
      chk("done_seen", 32'(done_cnt != base), 32'd1);
      repeat (2) tick();
   endtask

   int wb, db, hb, bb, eb;
   logic [31:0] w3[3];
   logic [31:0] w;
   logic [7:0]  csum;

   initial begin
      rst_n = 1'b0; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
      repeat (2) tick();
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_mem_we",     32'(mem_we),     32'd0);
      chk("rst_cpu_hold",   32'(cpu_hold),   32'd0);
      chk("rst_done",       32'(done),       32'd0);
      chk("rst_err",        32'(err),        32'd0);
      chk("rst_mem_addr",   mem_addr,        32'd0);
      chk("rst_mem_wdata",  mem_wdata,       32'd0);
      rst_n = 1'b1;
      tick();

      // one-word load, full rate
      wb = wa.size(); db = done_cnt; hb = hold_cnt; eb = exp_wc.size();
      start_load(1);
      send_word(32'hE3A00014, 0);
      send_byte(8'h97, 0);
      wait_done(db);
      chk("w1_count", 32'(wa.size() - wb), 32'd1);
      chk("w1_addr",  wa[wb], 32'h0);
      chk("w1_data",  wd[wb], 32'hE3A00014);
      chk("w1_lat",   32'(wc[wb]), 32'(exp_wc[eb]));
      chk("w1_done",  32'(done_cnt - db), 32'd1);
      chk("w1_err",   32'(last_err), 32'd0);
      chk("w1_time",  32'(done_cyc - st_cyc), 32'd7);
      chk("w1_hold",  32'(hold_cnt - hb), 32'd7);

      // three words with gaps and a stray start mid-load
      w3[0] = 32'hE3A00014; w3[1] = 32'hE3A01A01; w3[2] = 32'hE3A02103;
      wb = wa.size(); db = done_cnt; eb = exp_wc.size();
      start_load(3);
      send_word(w3[0], 3);
      start = 1'b1; num_words = CW'(5);
      tick();
      start = 1'b0;
      send_word(w3[1], 3);
      send_word(w3[2], 3);
      send_byte(8'hDC, 2);
      wait_done(db);
      chk("w3_count", 32'(wa.size() - wb), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk("w3_addr", wa[wb+i], 32'(4*i));
         chk("w3_data", wd[wb+i], w3[i]);
         chk("w3_lat",  32'(wc[wb+i]), 32'(exp_wc[eb+i]));
      end
      chk("w3_done", 32'(done_cnt - db), 32'd1);
      chk("w3_err",  32'(last_err), 32'd0);

      // bad checksum
      wb = wa.size(); db = done_cnt;
      start_load(1);
      send_word(32'hE3A00014, 0);
      send_byte(8'h00, 0);
      wait_done(db);
      chk("bad_count", 32'(wa.size() - wb), 32'd1);
      chk("bad_addr",  wa[wb], 32'h0);
      chk("bad_data",  wd[wb], 32'hE3A00014);
      chk("bad_err",   32'(last_err), 32'd1);

      // num_words = 0
      wb = wa.size(); db = done_cnt;
      start_load(0);
      wait_done(db);
      chk("zero_time",  32'(done_cyc - st_cyc), 32'd1);
      chk("zero_err",   32'(last_err), 32'd0);
      chk("zero_write", 32'(wa.size() - wb), 32'd0);

      // num_words = DEPTH+1
      wb = wa.size(); db = done_cnt; bb = br_cnt;
      start_load(DEPTH + 1);
      wait_done(db);
      chk("over_time",  32'(done_cyc - st_cyc), 32'd1);
      chk("over_err",   32'(last_err), 32'd1);
      chk("over_write", 32'(wa.size() - wb), 32'd0);
      chk("over_ready", 32'(br_cnt - bb), 32'd0);

      // full-depth load at full rate
      wb = wa.size(); db = done_cnt;
      csum = 8'h00;
      start_load(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         w = {8'(i), 8'(i * 3), ~8'(i), 8'h5A};
         csum = csum + w[31:24] + w[23:16] + w[15:8] + w[7:0];
         send_word(w, 0);
      end
      send_byte(csum, 0);
      wait_done(db);
      chk("full_count", 32'(wa.size() - wb), 32'(DEPTH));
      chk("full_last_addr", wa[wb+DEPTH-1], 32'h0FC);
      chk("full_last_data", wd[wb+DEPTH-1], {8'(DEPTH-1), 8'((DEPTH-1)*3), ~8'(DEPTH-1), 8'h5A});
      chk("full_time", 32'(done_cyc - st_cyc), 32'd322);
      chk("full_err",  32'(last_err), 32'd0);

      // reset mid-load
      wb = wa.size(); db = done_cnt;
      start_load(1);
      send_byte(8'hE3, 0);
      send_byte(8'hA0, 0);
      rst_n = 1'b0;
      tick();
      chk("mid_byte_ready", 32'(byte_ready), 32'd0);
      chk("mid_mem_we",     32'(mem_we),     32'd0);
      chk("mid_cpu_hold",   32'(cpu_hold),   32'd0);
      chk("mid_done",       32'(done),       32'd0);
      chk("mid_err",        32'(err),        32'd0);
      chk("mid_mem_addr",   mem_addr,        32'd0);
      chk("mid_mem_wdata",  mem_wdata,       32'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("mid_no_write", 32'(wa.size() - wb), 32'd0);
      chk("mid_no_done",  32'(done_cnt - db), 32'd0);
      start_load(1);
      send_word(32'h12345678, 0);
      send_byte(8'h14, 0);
      wait_done(db);
      chk("post_count", 32'(wa.size() - wb), 32'd1);
      chk("post_addr",  wa[wb], 32'h0);
      chk("post_data",  wd[wb], 32'h12345678);
      chk("post_err",   32'(last_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Byte-stream loader that writes a program image into the instruction RAM before the core runs. It accepts a counted, checksummed stream of bytes from a host-side byte source such as a UART receiver. It assembles the bytes MSB-first into 32-bit instruction words and issues one write per word at byte address 4·index, which matches the fetch-side word indexing (address >> 2). It holds the core in reset for the whole load and reports completion and error status.

## Interface
- DEPTH, 64: instruction RAM size in words; the largest legal image.
- CW, $clog2(DEPTH+1): width of the word-count input.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- num_words  in  CW  image length in words; latched when start is accepted.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction RAM write strobe.
- mem_addr  out  32  write byte address, always 4·word_index.
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  keeps the core in reset while high.
- done  out  1  one-cycle pulse at the end of a load.
- err  out  1  valid with done: checksum mismatch or oversize image.

## Operation
- States: IDLE, LOAD, WRITE, CHECK, DONE.
- **IDLE**
  - start=1 with num_words=0 → DONE with err=0.
  - start=1 with num_words>DEPTH → DONE with err=1. No bytes are consumed and no writes occur.
  - start=1 otherwise → LOAD. The loader latches num_words and clears word_index, byte_count and sum.
- **LOAD**
  - byte_ready=1.
  - An accepted byte (byte_valid & byte_ready at the edge) is handled as follows:
    - It shifts into the shift register: shreg ← {shreg[23:0], byte_data}.
    - It is added to sum: sum ← sum + byte_data, mod 256.
    - byte_count increments.
  - On the 4th accepted byte: byte_count wraps to 0 and the state goes to WRITE.
- **WRITE** (exactly one cycle)
  - mem_we=1, mem_addr={word_index,2'b00} zero-extended, mem_wdata=shreg, byte_ready=0.
  - Then word_index increments.
  - Next state is CHECK if word_index+1 = num_words, else LOAD.
- **CHECK**
  - byte_ready=1.
  - The accepted byte is the checksum. err_next = (byte_data ≠ sum). The byte is not added to sum.
  - Next state is DONE.
- **DONE** (exactly one cycle)
  - done=1, err=err_next. Then IDLE.
- start is ignored in every state except IDLE.
- Words already written stay written when the checksum fails. Only the err flag reports the failure.
- Idle output values: mem_addr and mem_wdata hold their last values, but are only meaningful while mem_we=1.

## Timing
- **Reset** (rst_n=0 at an edge): state ← IDLE. byte_ready, mem_we, cpu_hold, done and err ← 0. mem_addr, mem_wdata, counters and sum ← 0.
- **Reset mid-load:** the load is abandoned, the partial word is never written, and no done pulse is produced.
- **cpu_hold** rises in the cycle after start is accepted. It stays 1 through the DONE cycle and falls in the cycle after DONE.
- **byte_ready** is combinational from state only: 1 in LOAD and CHECK. It never depends on byte_valid.
- **Word write latency:** mem_we is asserted in the cycle immediately after the edge that accepts the word's 4th byte.
- **Full-rate stream:** with byte_valid held at 1, one word takes 5 cycles (4 bytes + 1 WRITE).
- **Total load time:** N-word load at full rate = 1 (start) + 5N + 1 (checksum) cycles, then 1 DONE cycle.
- **Input gaps:** byte_valid low stalls LOAD or CHECK indefinitely with no state change.
- **Bytes offered during WRITE, DONE or IDLE** are not accepted (byte_ready=0). The source must hold them.
- **Sum arithmetic:** 8-bit, wraps modulo 256.
- **word_index:** never exceeds DEPTH−1.

## Test plan
- **One-word load:** start, num_words=1, bytes E3,A0,00,14 back-to-back, then checksum 97. Required:
  - One mem_we pulse, 1 cycle after the 14 byte, with addr 0x0 and data 0xE3A00014.
  - done=1, err=0.
  - cpu_hold high from the cycle after start through the DONE cycle.
- **Three-word load with byte_valid gaps:**
  - Words E3A00014, E3A01A01, E3A02103 are sent with random idle cycles between bytes.
  - Required: writes at 0x0, 0x4, 0x8 with matching data; err=0; no write during any gap.
  - A start pulse mid-load is ignored.
- **Bad checksum:** one-word load as above, but the checksum byte is 00. Required: the word is still written at 0x0, and done=1 with err=1.
- **Edge counts:**
  - num_words=0 → done the cycle after start, err=0, no mem_we.
  - num_words=65 (DEPTH=64) → done the cycle after start, err=1, byte_ready never 1, no mem_we.
- **Full-depth load:** 64 words at full rate. Required: last write to 0xFC, done exactly 1+320+1 cycles after start.
- **Reset mid-load:** rst_n=0 after 2 bytes of word 1. Required:
  - All outputs return to 0 and no write or done occurs.
  - A subsequent clean one-word load succeeds at address 0x0.
